// File: rtl/conv_param_pkg.sv
// conv_param_pkg
// Shared definitions for the convolution parameter sequencer slice:
//   - default geometry / timing constants (DW, K, NF, GAP_CYC)
//   - sequencer state enumeration
//   - helper functions for address-bus width, index widths and the
//     parameter-word address map (K*K weights followed by one bias per filter)
package conv_param_pkg;

    localparam int DEF_DW      = 16;
    localparam int DEF_K       = 3;
    localparam int DEF_NF      = 2;
    localparam int DEF_GAP_CYC = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    // Number of parameter words occupied by one filter (K*K weights + bias).
    function automatic int words_per_filt(input int k);
        return k * k + 1;
    endfunction

    // Total number of parameter words held by the store.
    function automatic int total_words(input int nf, input int k);
        return nf * words_per_filt(k);
    endfunction

    // Width of the parameter word address bus.
    function automatic int calc_aw(input int nf, input int k);
        return (total_words(nf, k) > 1) ? $clog2(total_words(nf, k)) : 1;
    endfunction

    // Width of an index counting 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Address of weight (f, r, c).
    function automatic int weight_addr(input int f, input int r, input int c, input int k);
        return f * words_per_filt(k) + r * k + c;
    endfunction

    // Address of the bias word of filter f.
    function automatic int bias_addr(input int f, input int k);
        return f * words_per_filt(k) + k * k;
    endfunction

endpackage

// File: rtl/conv_param_seq_if.sv
// conv_param_seq_if
// Bundles the parameter write port, the run controls and the row stream of
// conv_param_seq.
//   master : the controller/consumer side (drives writes, start, loop_en,
//            out_ready; observes the stream and status)
//   slave  : the sequencer side
// Signals:
//   wr_en/wr_addr/wr_data   parameter word write port
//   start, loop_en          run request and continuous-mode select
//   out_ready               downstream accepts the current row
//   out_valid, filt_row,    row stream (column c at filt_row[c*DW +: DW]),
//   bias, filt_idx, row_idx bias of the current filter, current indices
//   last_row, last_filt     end-of-filter / last-filter flags (gated by out_valid)
//   busy, done              sequencer active, one-cycle completion pulse
interface conv_param_seq_if
    import conv_param_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int K  = DEF_K,
    parameter int NF = DEF_NF
);
    localparam int AW = calc_aw(NF, K);
    localparam int FW = idx_w(NF);
    localparam int RW = idx_w(K);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic              loop_en;
    logic              out_ready;
    logic              out_valid;
    logic [K*DW-1:0]   filt_row;
    logic [DW-1:0]     bias;
    logic [FW-1:0]     filt_idx;
    logic [RW-1:0]     row_idx;
    logic              last_row;
    logic              last_filt;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, start, loop_en, out_ready,
        input  out_valid, filt_row, bias, filt_idx, row_idx,
               last_row, last_filt, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, loop_en, out_ready,
        output out_valid, filt_row, bias, filt_idx, row_idx,
               last_row, last_filt, busy, done
    );

endinterface

// File: rtl/conv_param_store.sv
// conv_param_store
// Register array holding NF filters of K*K signed weights plus one bias each.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears every word)
//   wr_en         write strobe, already qualified by the sequencer
//   wr_addr       word address; addresses past the last word are ignored
//   wr_data       word to write
//   rd_filt       filter selected for the combinational read
//   rd_row        kernel row selected for the combinational read
//   rd_row_data   K words of the selected row, column c at [c*DW +: DW]
//   rd_bias       bias of the selected filter
module conv_param_store
    import conv_param_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int K  = DEF_K,
    parameter int NF = DEF_NF,
    localparam int AW = calc_aw(NF, K),
    localparam int FW = idx_w(NF),
    localparam int RW = idx_w(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [FW-1:0]     rd_filt,
    input  logic [RW-1:0]     rd_row,
    output logic [K*DW-1:0]   rd_row_data,
    output logic [DW-1:0]     rd_bias
);

    localparam int NW = total_words(NF, K);

    logic [DW-1:0] mem [NW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < NW)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_row_data = '0;
        for (int c = 0; c < K; c++) begin
            rd_row_data[c*DW +: DW] =
                mem[AW'(weight_addr(int'(rd_filt), int'(rd_row), c, K))];
        end
        rd_bias = mem[AW'(bias_addr(int'(rd_filt), K))];
    end

endmodule

// File: rtl/conv_param_seq.sv
// conv_param_seq
// Holds NF convolution filters (K x K weights + bias each) and streams them
// row by row over a valid/ready handshake, with GAP_CYC idle cycles between
// filters and an optional continuous (looping) mode.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset; aborts any run, clears all parameters
//   bus   conv_param_seq_if.slave: write port, start/loop_en, row stream,
//         busy/done status
// Timing: start sampled in IDLE -> one LOAD cycle -> first row valid.
// Between filters out_valid stays low for the GAP_CYC gap cycles plus the
// LOAD cycle that fetches the next filter's first row.
module conv_param_seq
    import conv_param_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int K       = DEF_K,
    parameter int NF      = DEF_NF,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             rst,
    conv_param_seq_if.slave  bus
);

    localparam int AW = calc_aw(NF, K);
    localparam int FW = idx_w(NF);
    localparam int RW = idx_w(K);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [FW-1:0] LAST_F  = FW'(NF - 1);
    localparam logic [RW-1:0] LAST_R  = RW'(K - 1);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYC - 1);

    seq_state_t        state_q, state_n;
    logic [FW-1:0]     filt_q, filt_n;
    logic [RW-1:0]     row_q, row_n;
    logic [GW-1:0]     gap_q, gap_n;
    logic              valid_q, valid_n;
    logic              done_q, done_n;
    logic              load_row;
    logic [K*DW-1:0]   row_data_q;
    logic [DW-1:0]     bias_q;
    logic [K*DW-1:0]   store_row;
    logic [DW-1:0]     store_bias;
    logic              store_wr;

    // Parameters may only change while the sequencer is idle so a run always
    // sees one consistent filter set.
    assign store_wr = bus.wr_en && (state_q == ST_IDLE);

    // The store is read at the indices the sequencer is about to present, so
    // the output row register loads the next row on the accepting edge with
    // no bubble.
    conv_param_store #(
        .DW (DW),
        .K  (K),
        .NF (NF)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (store_wr),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .rd_filt     (filt_n),
        .rd_row      (row_n),
        .rd_row_data (store_row),
        .rd_bias     (store_bias)
    );

    always_comb begin
        state_n  = state_q;
        filt_n   = filt_q;
        row_n    = row_q;
        gap_n    = gap_q;
        valid_n  = valid_q;
        done_n   = 1'b0;
        load_row = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_LOAD;
                    filt_n  = '0;
                    row_n   = '0;
                end
            end

            ST_LOAD: begin
                state_n  = ST_STREAM;
                valid_n  = 1'b1;
                load_row = 1'b1;
            end

            // out_valid is always high here, so out_ready alone marks a handshake.
            ST_STREAM: begin
                if (bus.out_ready) begin
                    if (row_q != LAST_R) begin
                        row_n    = row_q + RW'(1);
                        load_row = 1'b1;
                    end else if ((filt_q != LAST_F) || bus.loop_en) begin
                        valid_n = 1'b0;
                        row_n   = '0;
                        filt_n  = (filt_q == LAST_F) ? '0 : filt_q + FW'(1);
                        gap_n   = '0;
                        state_n = (GAP_CYC == 0) ? ST_LOAD : ST_GAP;
                    end else begin
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_DONE;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_END) begin
                    state_n = ST_LOAD;
                end else begin
                    gap_n = gap_q + GW'(1);
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            filt_q     <= '0;
            row_q      <= '0;
            gap_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            row_data_q <= '0;
            bias_q     <= '0;
        end else begin
            state_q <= state_n;
            filt_q  <= filt_n;
            row_q   <= row_n;
            gap_q   <= gap_n;
            valid_q <= valid_n;
            done_q  <= done_n;
            if (load_row) begin
                row_data_q <= store_row;
                bias_q     <= store_bias;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.filt_row  = row_data_q;
    assign bus.bias      = bias_q;
    assign bus.filt_idx  = filt_q;
    assign bus.row_idx   = row_q;
    assign bus.last_row  = valid_q && (row_q == LAST_R);
    assign bus.last_filt = valid_q && (filt_q == LAST_F);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;

endmodule
